q15_mul_scheduler: RTL and testbench

//   Shares one combinational Q15Multiplier (64-bit signed fixed point, 48 fraction bits) between NREQ requesters.

---
 rtl/q15_pkg.sv | 15 +
 rtl/rr_pick.sv | 36 +++
 rtl/q15_mul_scheduler.sv | 134 +++++++++++++
 tb/tb_q15_mul_scheduler.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/q15_pkg.sv
// Shared Q15 fixed-point definitions: 64-bit signed, 48 fraction bits.
// Special encodings are only flagged by the scheduler. They are never interpreted.
package q15_pkg;

  localparam int          Q15_W       = 64;
  localparam int          Q15_FRAC    = 48;
  localparam logic [63:0] Q15_NAN     = 64'h8000000000000000;
  localparam logic [63:0] Q15_POS_INF = 64'h7fffffffffffffff;
  localparam logic [63:0] Q15_NEG_INF = 64'hffffffffffffffff;

  function automatic logic q15_is_nan(input logic [Q15_W-1:0] v);
    return v == Q15_NAN;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: returns the first eligible index at or after ptr_i,
// wrapping at N, as a one-hot grant, a binary index and an any flag.
module rr_pick #(
  parameter  int N  = 4,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  elig_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [PW-1:0] idx_o,
  output logic          any_o
);

  int            j;
  logic [PW-1:0] jj;

  // Scan N positions starting at the pointer and stop at the first eligible one.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    j       = 0;
    jj      = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      jj = PW'(j);
      if (!any_o && elig_i[jj]) begin
        any_o       = 1'b1;
        grant_o[jj] = 1'b1;
        idx_o       = jj;
      end
    end
  end

endmodule

// File: rtl/q15_mul_scheduler.sv
// Shares one external combinational Q15 multiplier between NREQ requesters.
// Round-robin issue with one op per cycle. Each requester has at most one op outstanding.
// After the issue register there are MUL_LAT result stages, and the response comes from the last stage.
// Optional feature: define Q15_MUL_SCHED_STATS_EN to add stat_issue/stat_conflict counters.
module q15_mul_scheduler
  import q15_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*Q15_W-1:0] req_a,
  input  logic [NREQ*Q15_W-1:0] req_b,
  output logic [Q15_W-1:0]      mul_a,
  output logic [Q15_W-1:0]      mul_b,
  input  logic [Q15_W-1:0]      mul_res,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [Q15_W-1:0]      rsp_res,
  output logic                  rsp_nan
`ifdef Q15_MUL_SCHED_STATS_EN
  ,
  output logic [31:0]           stat_issue,
  output logic [31:0]           stat_conflict
`endif
);

  localparam int PW = $clog2(NREQ);

  logic [NREQ-1:0]                 elig, grant;
  logic [PW-1:0]                   gidx;
  logic                            gany;

  logic [NREQ-1:0]                 busy_q, busy_d;
  logic [PW-1:0]                   ptr_q, ptr_d;
  logic                            iss_vld_q;
  logic [PW-1:0]                   iss_tag_q;
  logic [Q15_W-1:0]                mul_a_q, mul_b_q;
  logic [MUL_LAT:1]                vld_q;
  logic [MUL_LAT:1][PW-1:0]        tag_q;
  logic [MUL_LAT:1][Q15_W-1:0]     res_q;

  // A requester that still has an op in flight cannot be granted. This also covers its own response cycle.
  assign elig = req_valid & ~busy_q;

  rr_pick #(.N(NREQ)) u_pick (
    .elig_i  (elig),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (gidx),
    .any_o   (gany)
  );

  // The grant doubles as ready, so any asserted ready bit is a completed handshake.
  assign req_ready = grant;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;

  // Next pointer and busy set. A requester's busy bit is released at the end of its response cycle.
  always_comb begin
    ptr_d  = ptr_q;
    busy_d = busy_q;
    if (vld_q[MUL_LAT]) busy_d[tag_q[MUL_LAT]] = 1'b0;
    if (gany) begin
      busy_d[gidx] = 1'b1;
      ptr_d        = (gidx == PW'(NREQ-1)) ? '0 : gidx + PW'(1);
    end
  end

  // Issue register, result shift pipeline and arbitration state. The pipeline never stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q    <= '0;
      ptr_q     <= '0;
      iss_vld_q <= 1'b0;
      iss_tag_q <= '0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      vld_q     <= '0;
      tag_q     <= '0;
      res_q     <= '0;
    end else begin
      busy_q    <= busy_d;
      ptr_q     <= ptr_d;
      iss_vld_q <= gany;
      if (gany) begin
        iss_tag_q <= gidx;
        mul_a_q   <= req_a[int'(gidx)*Q15_W +: Q15_W];
        mul_b_q   <= req_b[int'(gidx)*Q15_W +: Q15_W];
      end
      vld_q[1] <= iss_vld_q;
      tag_q[1] <= iss_tag_q;
      res_q[1] <= mul_res;
      for (int k = 2; k <= MUL_LAT; k++) begin
        vld_q[k] <= vld_q[k-1];
        tag_q[k] <= tag_q[k-1];
        res_q[k] <= res_q[k-1];
      end
    end
  end

  // Response decode from the final stage. The result is forced to zero when no response is valid.
  always_comb begin
    rsp_valid = '0;
    rsp_res   = '0;
    rsp_nan   = 1'b0;
    if (vld_q[MUL_LAT]) begin
      rsp_valid[tag_q[MUL_LAT]] = 1'b1;
      rsp_res                   = res_q[MUL_LAT];
      rsp_nan                   = q15_is_nan(res_q[MUL_LAT]);
    end
  end

`ifdef Q15_MUL_SCHED_STATS_EN
  logic [31:0] stat_issue_q, stat_conflict_q;

  // Wrapping counters: one counts handshakes, the other counts cycles with two or more eligible requesters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_issue_q    <= '0;
      stat_conflict_q <= '0;
    end else begin
      if (gany) stat_issue_q <= stat_issue_q + 32'd1;
      if ($countones(elig) >= 2) stat_conflict_q <= stat_conflict_q + 32'd1;
    end
  end

  assign stat_issue    = stat_issue_q;
  assign stat_conflict = stat_conflict_q;
`endif

endmodule

// File: tb/tb_q15_mul_scheduler.sv
// Scoreboard bench for q15_mul_scheduler. The stimulus drives directed vectors whose
// results were computed by hand. Each expected grant pushes the expected response, and a
// monitor pops and compares on every rsp_valid.
module tb_q15_mul_scheduler;

  localparam int NREQ    = 4;
  localparam int MUL_LAT = 2;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*64-1:0]   req_a, req_b;
  logic [63:0]          mul_a, mul_b, mul_res;
  logic [NREQ-1:0]      rsp_valid;
  logic [63:0]          rsp_res;
  logic                 rsp_nan;
`ifdef Q15_MUL_SCHED_STATS_EN
  logic [31:0]          stat_issue, stat_conflict;
`endif

  logic [63:0] opa [NREQ];
  logic [63:0] opb [NREQ];
  logic [63:0] exp_r [NREQ];
  logic        exp_n [NREQ];

  typedef struct {
    int          idx;
    logic [63:0] res;
    logic        nan;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  q15_mul_scheduler #(.NREQ(NREQ), .MUL_LAT(MUL_LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_res   (mul_res),
    .rsp_valid (rsp_valid),
    .rsp_res   (rsp_res),
    .rsp_nan   (rsp_nan)
`ifdef Q15_MUL_SCHED_STATS_EN
    ,
    .stat_issue    (stat_issue),
    .stat_conflict (stat_conflict)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference multiplier: signed Q48 product, truncated to 64 bits.
  function automatic logic [63:0] q15_mul(input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] p;
    p = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
    return p[111:48];
  endfunction
  assign mul_res = q15_mul(mul_a, mul_b);

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_a[64*i +: 64] = opa[i];
      req_b[64*i +: 64] = opb[i];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic clr_ops();
    for (int i = 0; i < NREQ; i++) begin
      opa[i] = '0; opb[i] = '0; exp_r[i] = '0; exp_n[i] = 1'b0;
    end
  endtask

  // One cycle: drive valid, check ready at negedge, record the expected response when granted.
  task automatic step(input logic [3:0] v, input logic [3:0] er, input bit push);
    req_valid = v;
    @(negedge clk);
    chk("req_ready", 64'(req_ready), 64'(er));
    if (push) begin
      for (int i = 0; i < NREQ; i++)
        if (er[i]) sb.push_back('{i, exp_r[i], exp_n[i], cyc + 1 + MUL_LAT});
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic drain();
    repeat (6) step(4'b0000, 4'b0000, 1'b0);
  endtask

  // Monitor: pop and compare on every response. An unexpected response is a failure.
  always @(negedge clk) begin
    if (!reset) begin
      if (rsp_valid != '0) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_rsp: got rsp_valid=%b expected none (cycle %0d)", rsp_valid, cyc);
        end else begin
          exp_t e;
          logic [3:0] oh;
          e  = sb.pop_front();
          oh = 4'b0001 << e.idx;
          chk("rsp_valid", 64'(rsp_valid), 64'(oh));
          chk("rsp_res", rsp_res, e.res);
          chk("rsp_nan", 64'(rsp_nan), 64'(e.nan));
          chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
        end
      end else begin
        chk("idle_nan", 64'(rsp_nan), 64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_ops();

    // 1: reset, then idle
    do_reset();
    repeat (10) step(4'b0000, 4'b0000, 1'b0);
    @(negedge clk);
    chk("rst_mul_a", mul_a, 64'd0);
    chk("rst_mul_b", mul_b, 64'd0);
    chk("rst_rsp_res", rsp_res, 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;

    // 2: req0 alone, 2.0 * 3.0
    clr_ops();
    opa[0] = 64'h0002000000000000; opb[0] = 64'h0003000000000000;
    exp_r[0] = 64'h0006000000000000;
    step(4'b0001, 4'b0001, 1'b1);
    drain();

    // 3: all requesters valid every cycle starting from pointer 0
    do_reset();
    clr_ops();
    opa[0] = 64'h0001000000000000; exp_r[0] = 64'h0002000000000000;
    opa[1] = 64'h0002000000000000; exp_r[1] = 64'h0004000000000000;
    opa[2] = 64'h0003000000000000; exp_r[2] = 64'h0006000000000000;
    opa[3] = 64'h0004000000000000; exp_r[3] = 64'h0008000000000000;
    for (int i = 0; i < NREQ; i++) opb[i] = 64'h0002000000000000;
    step(4'b1111, 4'b0001, 1'b1);
    step(4'b1111, 4'b0010, 1'b1);
    step(4'b1111, 4'b0100, 1'b1);
    step(4'b1111, 4'b1000, 1'b1);
    step(4'b1111, 4'b0001, 1'b1);   // req0 released after its response cycle
    step(4'b1111, 4'b0010, 1'b1);
    drain();
`ifdef Q15_MUL_SCHED_STATS_EN
    @(negedge clk);
    chk("stat_issue", 64'(stat_issue), 64'd6);
    chk("stat_conflict", 64'(stat_conflict), 64'd3);
    @(posedge clk); #1;
`endif

    // 4: req2 holds valid through its own response cycle
    do_reset();
    clr_ops();
    opa[2] = 64'hFFFE800000000000; opb[2] = 64'h0002000000000000;
    exp_r[2] = 64'hFFFD000000000000;
    step(4'b0100, 4'b0100, 1'b1);
    step(4'b0100, 4'b0000, 1'b0);
    step(4'b0100, 4'b0000, 1'b0);
    step(4'b0100, 4'b0000, 1'b0);   // response cycle: still busy
    step(4'b0100, 4'b0100, 1'b1);
    drain();

    // 5: NaN flagging, plus a non-NaN result and a +inf result
    do_reset();
    clr_ops();
    opa[0] = 64'h0000800000000000; opb[0] = 64'h0000800000000000;
    exp_r[0] = 64'h0000400000000000;
    opa[1] = 64'h8000000000000000; opb[1] = 64'h0001000000000000;
    exp_r[1] = 64'h8000000000000000; exp_n[1] = 1'b1;
    opa[3] = 64'h7fffffffffffffff; opb[3] = 64'h0001000000000000;
    exp_r[3] = 64'h7fffffffffffffff;
    step(4'b1011, 4'b0001, 1'b1);
    step(4'b1010, 4'b0010, 1'b1);
    step(4'b1000, 4'b1000, 1'b1);
    drain();

    // 6: reset one cycle after two handshakes drops both ops
    do_reset();
    clr_ops();
    opa[0] = 64'h0001000000000000; opb[0] = 64'hFFFF000000000000;
    exp_r[0] = 64'hFFFF000000000000;
    opa[1] = 64'h0000400000000000; opb[1] = 64'h0004000000000000;
    exp_r[1] = 64'h0001000000000000;
    step(4'b0011, 4'b0001, 1'b0);
    step(4'b0010, 4'b0010, 1'b0);
    reset = 1'b1;
    req_valid = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (4) step(4'b0000, 4'b0000, 1'b0);
    step(4'b0011, 4'b0001, 1'b1);   // pointer back at 0, busy cleared
    step(4'b0010, 4'b0010, 1'b1);
    drain();

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
